// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage initiator for the multi-cycle divider.
// It owns the start/cancel/ready handshake for DIV/DIVU. It holds the operands
// and the signed mode steady while the divider runs, stalls the pipeline until
// a result is back, aborts on flush, and presents {remainder, quotient} as a
// HI/LO write for the single DONE cycle, or longer while EX is held.
module div_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        signed_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // The drain counter only ever holds DRAIN_CYCLES-1 down to 0.
    localparam int CW = $clog2(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } DivState;

    DivState state_q, state_d;
    logic [CW-1:0] drainCnt_q, drainCnt_d;
    logic          divStart_q, divStart_d;
    logic          divCancel_q, divCancel_d;
    logic          divSigned_q, divSigned_d;
    logic [31:0]   opData1_q, opData1_d;
    logic [31:0]   opData2_q, opData2_d;
    logic [31:0]   hiResult_q, hiResult_d;
    logic [31:0]   loResult_q, loResult_d;

    // Next-state logic. Cancel defaults low, so it is only a one-cycle pulse.
    // Start drops on every exit from BUSY, and that drop frees the divider.
    always_comb begin
        state_d     = state_q;
        drainCnt_d  = drainCnt_q;
        divStart_d  = divStart_q;
        divCancel_d = 1'b0;
        divSigned_d = divSigned_q;
        opData1_d   = opData1_q;
        opData2_d   = opData2_q;
        hiResult_d  = hiResult_q;
        loResult_d  = loResult_q;

        case (state_q)
            IDLE: begin
                divStart_d = 1'b0;
                if (div_req_i && !flush_i) begin
                    opData1_d   = reg1_i;
                    opData2_d   = reg2_i;
                    divSigned_d = signed_i;
                    divStart_d  = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    divStart_d  = 1'b0;
                    divCancel_d = 1'b1;
                    drainCnt_d  = CW'(DRAIN_CYCLES - 1);
                    state_d     = DRAIN;
                end else if (div_ready_i) begin
                    hiResult_d = div_result_i[63:32];
                    loResult_d = div_result_i[31:0];
                    divStart_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                divStart_d = 1'b0;
                if (!hold_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                divStart_d = 1'b0;
                if (drainCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drainCnt_d = drainCnt_q - CW'(1);
                end
            end
            default: begin
                divStart_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset clears everything, so a reset that
    // lands mid-divide aborts it silently; the divider shares the same reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drainCnt_q  <= '0;
            divStart_q  <= 1'b0;
            divCancel_q <= 1'b0;
            divSigned_q <= 1'b0;
            opData1_q   <= '0;
            opData2_q   <= '0;
            hiResult_q  <= '0;
            loResult_q  <= '0;
        end else begin
            state_q     <= state_d;
            drainCnt_q  <= drainCnt_d;
            divStart_q  <= divStart_d;
            divCancel_q <= divCancel_d;
            divSigned_q <= divSigned_d;
            opData1_q   <= opData1_d;
            opData2_q   <= opData2_d;
            hiResult_q  <= hiResult_d;
            loResult_q  <= loResult_d;
        end
    end

    assign div_start_o   = divStart_q;
    assign div_cancel_o  = divCancel_q;
    assign div_signed_o  = divSigned_q;
    assign div_opdata1_o = opData1_q;
    assign div_opdata2_o = opData2_q;

    // Stall drops in DONE so the instruction can leave EX with its result.
    assign stallreq_o = div_req_i & ~flush_i & (state_q != DONE);
    assign whilo_o    = (state_q == DONE) & ~flush_i;
    assign hi_o       = (state_q == DONE) ? hiResult_q : 32'd0;
    assign lo_o       = (state_q == DONE) ? loResult_q : 32'd0;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl. The bench plays the divider's part.
// Each accepted divide pushes its expected {hi, lo} onto a scoreboard queue,
// and that entry is popped and compared when the DUT raises whilo.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        divReq;
    logic        signedIn;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        flush;
    logic        hold;
    logic [63:0] divResult;
    logic        divReady;
    logic        divStart;
    logic        divCancel;
    logic        divSigned;
    logic [31:0] opData1;
    logic [31:0] opData2;
    logic        stallReq;
    logic        whilo;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    int vecCount  = 0;
    int failCount = 0;
    logic [63:0] expQ[$];

    div_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req_i    (divReq),
        .signed_i     (signedIn),
        .reg1_i       (reg1),
        .reg2_i       (reg2),
        .flush_i      (flush),
        .hold_i       (hold),
        .div_result_i (divResult),
        .div_ready_i  (divReady),
        .div_start_o  (divStart),
        .div_cancel_o (divCancel),
        .div_signed_o (divSigned),
        .div_opdata1_o(opData1),
        .div_opdata2_o(opData2),
        .stallreq_o   (stallReq),
        .whilo_o      (whilo),
        .hi_o         (hiOut),
        .lo_o         (loOut)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Keeps the run from hanging if the bench or the DUT gets stuck.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    // The divider's answer: {remainder, quotient}. Divide-by-zero returns all zeros.
    function automatic logic [63:0] divModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return 64'd0;
        if (sgn) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic fl, input logic hd, input logic rdy,
                                 input logic [63:0] res);
        divReq    = req;
        signedIn  = sgn;
        reg1      = a;
        reg2      = b;
        flush     = fl;
        hold      = hd;
        divReady  = rdy;
        divResult = res;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full divide, starting in an IDLE cycle. Operand and sign inputs are
    // scrambled during BUSY, so the held values must come from the DUT's registers.
    // Returns in the final DONE cycle, which has hold low.
    task automatic runDivide(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                             input logic [31:0] expHi, input logic [31:0] expLo,
                             input int busyCycles, input int holdCycles);
        logic [63:0] exp;
        int waitCnt;
        expQ.push_back({expHi, expLo});
        applyStimulus(1'b1, sgn, a, b, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("req_start_low", 64'(divStart), 64'd0);
        checkOutput("req_stall", 64'(stallReq), 64'd1);
        tick;
        for (int i = 0; i < busyCycles; i++) begin
            applyStimulus(1'b1, ~sgn, ~a, ~b, 1'b0, 1'b0, 1'b0, 64'd0);
            checkOutput("busy_start", 64'(divStart), 64'd1);
            checkOutput("busy_op1", 64'(opData1), 64'(a));
            checkOutput("busy_op2", 64'(opData2), 64'(b));
            checkOutput("busy_signed", 64'(divSigned), 64'(sgn));
            checkOutput("busy_stall", 64'(stallReq), 64'd1);
            checkOutput("busy_whilo", 64'(whilo), 64'd0);
            tick;
        end
        applyStimulus(1'b1, ~sgn, ~a, ~b, 1'b0, 1'b0, 1'b1, divModel(a, b, sgn));
        checkOutput("ready_start_held", 64'(divStart), 64'd1);
        tick;
        waitCnt = 0;
        applyStimulus(1'b1, sgn, a, b, 1'b0, 1'b0, 1'b0, 64'd0);
        while (whilo !== 1'b1 && waitCnt < 8) begin
            tick;
            applyStimulus(1'b1, sgn, a, b, 1'b0, 1'b0, 1'b0, 64'd0);
            waitCnt++;
        end
        checkOutput("done_latency", 64'(waitCnt), 64'd0);
        exp = expQ.pop_front();
        for (int h = 0; h <= holdCycles; h++) begin
            applyStimulus(1'b1, sgn, a, b, 1'b0, (h < holdCycles), 1'b0, 64'd0);
            checkOutput("done_whilo", 64'(whilo), 64'd1);
            checkOutput("done_hi", 64'(hiOut), 64'(exp[63:32]));
            checkOutput("done_lo", 64'(loOut), 64'(exp[31:0]));
            checkOutput("done_stall", 64'(stallReq), 64'd0);
            checkOutput("done_start", 64'(divStart), 64'd0);
            if (h < holdCycles) tick;
        end
    endtask

    initial begin
        $display("[TB] div_ctrl directed run");

        // Reset: all outputs clear; stall follows the request.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;
        tick;
        checkOutput("rst_start", 64'(divStart), 64'd0);
        checkOutput("rst_cancel", 64'(divCancel), 64'd0);
        checkOutput("rst_signed", 64'(divSigned), 64'd0);
        checkOutput("rst_op1", 64'(opData1), 64'd0);
        checkOutput("rst_op2", 64'(opData2), 64'd0);
        checkOutput("rst_whilo", 64'(whilo), 64'd0);
        checkOutput("rst_hilo", {hiOut, loOut}, 64'd0);
        checkOutput("rst_stall_req", 64'(stallReq), 64'd1);
        applyStimulus(1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b0, 64'd0);
        checkOutput("rst_stall_flush", 64'(stallReq), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("rst_stall_noreq", 64'(stallReq), 64'd0);
        tick;
        rst = 1'b0;

        // DIVU 100/7.
        runDivide(32'h64, 32'h7, 1'b0, 32'h2, 32'hE, 4, 0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("idle_whilo", 64'(whilo), 64'd0);
        checkOutput("idle_hilo", {hiOut, loOut}, 64'd0);
        checkOutput("idle_start", 64'(divStart), 64'd0);
        tick;

        // DIV -7/2.
        runDivide(32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 5, 0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;

        // Divide by zero: ready on the second BUSY cycle, and zeros pass through.
        runDivide(32'd123, 32'd0, 1'b0, 32'd0, 32'd0, 1, 0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;

        // Flush at BUSY cycle 10, then a request that arrives during DRAIN.
        applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b0, 1'b0, 1'b0, 64'd0);
            checkOutput("fl_busy_start", 64'(divStart), 64'd1);
            tick;
        end
        applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b1, 1'b0, 1'b0, 64'd0);
        checkOutput("fl_stall_flush", 64'(stallReq), 64'd0);
        checkOutput("fl_cancel_pre", 64'(divCancel), 64'd0);
        tick;
        applyStimulus(1'b1, 1'b0, 32'd77, 32'd3, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("fl_cancel_pulse", 64'(divCancel), 64'd1);
        checkOutput("fl_drain1_start", 64'(divStart), 64'd0);
        checkOutput("fl_drain1_stall", 64'(stallReq), 64'd1);
        checkOutput("fl_drain1_whilo", 64'(whilo), 64'd0);
        tick;
        applyStimulus(1'b1, 1'b0, 32'd77, 32'd3, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("fl_cancel_once", 64'(divCancel), 64'd0);
        checkOutput("fl_drain2_start", 64'(divStart), 64'd0);
        checkOutput("fl_drain2_stall", 64'(stallReq), 64'd1);
        checkOutput("fl_drain2_whilo", 64'(whilo), 64'd0);
        tick;
        checkOutput("fl_idle_start", 64'(divStart), 64'd0);
        checkOutput("fl_idle_op1", 64'(opData1), 64'd50);
        runDivide(32'd77, 32'd3, 1'b0, 32'd2, 32'd25, 2, 0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;

        // Flush and ready in the same cycle: the flush wins and the result is lost.
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd4, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;
        tick;
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd4, 1'b1, 1'b0, 1'b1, divModel(32'd9, 32'd4, 1'b0));
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("flrdy_cancel", 64'(divCancel), 64'd1);
        checkOutput("flrdy_whilo", 64'(whilo), 64'd0);
        checkOutput("flrdy_hilo", {hiOut, loOut}, 64'd0);
        tick;
        tick;
        checkOutput("flrdy_whilo_after", 64'(whilo), 64'd0);

        // Back-to-back divides, the second one held in DONE for 3 cycles.
        runDivide(32'hFFFFFFFF, 32'h10, 1'b0, 32'hF, 32'h0FFFFFFF, 3, 0);
        tick;
        runDivide(32'd100, 32'hFFFFFFF9, 1'b1, 32'h2, 32'hFFFFFFF2, 2, 3);
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;

        // Flush during a held DONE: no write, and the block returns to IDLE.
        runDivide(32'd20, 32'd6, 1'b0, 32'd2, 32'd3, 1, 0);
        applyStimulus(1'b1, 1'b0, 32'd20, 32'd6, 1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("dflush_whilo", 64'(whilo), 64'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 64'd0);
        checkOutput("dflush_idle_whilo", 64'(whilo), 64'd0);
        checkOutput("dflush_idle_hilo", {hiOut, loOut}, 64'd0);
        tick;

        // Reset at BUSY cycle 5.
        applyStimulus(1'b1, 1'b1, 32'd1000, 32'd10, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 32'd1000, 32'd10, 1'b0, 1'b0, 1'b0, 64'd0);
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'd1000, 32'd10, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("mrst_start", 64'(divStart), 64'd0);
        checkOutput("mrst_cancel", 64'(divCancel), 64'd0);
        checkOutput("mrst_ops", {opData1, opData2}, 64'd0);
        checkOutput("mrst_signed", 64'(divSigned), 64'd0);
        checkOutput("mrst_stall_req", 64'(stallReq), 64'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        checkOutput("mrst_stall_noreq", 64'(stallReq), 64'd0);
        runDivide(32'd1000, 32'd10, 1'b0, 32'd0, 32'd100, 2, 0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick;

        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
